fp_mul_iterative: RTL and testbench
===================================

Name: fp_mul_iterative

Overview:
- Parametrised, sequential successor to the team's combinational single-precision multiplier.
- Multiplies two IEEE-754-style floats using a radix-2^BITS_PER_CYCLE shift-add mantissa core.
- Rounds round-to-nearest-even and raises sticky-free per-result exception flags.
- Sits behind a valid/ready handshake on both sides, so the FP datapath can stall it without glue.

Parameters:
EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
MAN_W, 23, stored fraction width; significand is MAN_W+1 bits with the hidden bit.
BITS_PER_CYCLE, 1, multiplier bits consumed per MULT cycle; must divide MAN_W+1. N = (MAN_W+1)/BITS_PER_CYCLE.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands a, b present.
in_ready  out  1  block idle and can accept; high only in IDLE.
a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
b  in  1+EXP_W+MAN_W  operand B.
out_valid  out  1  result and flags valid; high only in DONE.
out_ready  in  1  consumer accepts result.
result  out  1+EXP_W+MAN_W  product.
flag_invalid  out  1  inf x 0.
flag_overflow  out  1  result rounded to infinity.
flag_underflow  out  1  result flushed to zero.
flag_inexact  out  1  rounded result differs from exact product.

Behaviour:
- Reset (rst=1 at edge): state goes to IDLE. out_valid=0, result=0, all flags=0, accumulator and counter cleared. in_ready=1 in the cycle after reset.
- Reset mid-operation, from any state: the in-flight operation is discarded and no output is produced.
- States: IDLE -> CLASSIFY -> (MULT -> ROUND ->) DONE -> IDLE.
- IDLE: a/b are registered when in_valid & in_ready, then go to CLASSIFY. a/b are ignored in every other state.
- CLASSIFY: decode both operands. Exponent 0 means zero; subnormals are treated as zero (DAZ). Exponent all-ones with frac=0 is inf; with frac!=0 it is NaN. sign = sa ^ sb.
- Special cases (CLASSIFY -> DONE directly):
  - Any NaN -> canonical qNaN {0, all-ones, 1 followed by zeros}; flags 0.
  - inf x zero -> canonical qNaN; flag_invalid=1.
  - inf x finite nonzero -> {sign, inf}.
  - zero x finite -> {sign, 0}.
  - Otherwise go to MULT: load counter=0 and acc=0, and set exp = ea + eb - BIAS in a signed EXP_W+2-bit register.
- MULT, one chunk per cycle:
  - acc += ma x mb[chunk], with chunks taken LSB first and shifted into place.
  - acc is 2(MAN_W+1) bits. The final acc is the exact product for every legal BITS_PER_CYCLE.
  - After N cycles go to ROUND.
- ROUND, one cycle:
  - Normalise: if acc MSB=1, take the top MAN_W+1 bits from the MSB and set exp+1. Otherwise take them from MSB-1.
  - Guard is the next bit below the kept bits; sticky is the OR of all remaining bits.
  - Round up iff G & (S | LSB).
  - If rounding carries out, the significand becomes 1.0 and exp+1.
  - If exp >= 2^EXP_W-1: result {sign, inf}, flag_overflow=1, flag_inexact=1.
  - If exp <= 0: result {sign, 0} (FTZ), flag_underflow=1, flag_inexact=1.
  - Else: result {sign, exp[EXP_W-1:0], significand without hidden bit}, flag_inexact = G|S.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable while out_ready=0.
  - On out_valid & out_ready go to IDLE. out_valid drops next cycle and in_ready rises next cycle.
  - No accept occurs in the same cycle as a result handshake.
- Latency, for accept in cycle c:
  - Special case: out_valid first high in cycle c+2.
  - Normal path: out_valid first high in cycle c+N+3 (27 at defaults).
- Throughput is one operation per (latency + 1) cycles at best.
- Flags are per-result, not accumulating; they are overwritten for every operation.

Test Plan:
1. a=0x40400000 (3.0), b=0x40000000 (2.0), accepted in cycle c, out_ready=1 -> result=0x40C00000 in cycle c+27, all flags 0; in_ready=1 in cycle c+28.
2. RNE tie-to-even: a=0x3F800001, b=0x3FC00000 -> result=0x3FC00002, flag_inexact=1. Then 0x3FC00000 x 0x3FC00000 -> 0x40100000, inexact=0.
3. Overflow/underflow:
   - 0x7F000000 x 0x40000000 -> 0x7F800000, overflow=1, inexact=1.
   - 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
4. Specials, each at latency 2:
   - 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
   - 0xFF800000 x 0x40000000 -> 0xFF800000.
   - 0x7FC00001 x 0x3F800000 -> 0x7FC00000.
   - 0x00000001 (subnormal) x 0xC0000000 -> 0x80000000.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags unchanged and in_ready=0 throughout; in_valid with new operands during this period is ignored. Releasing out_ready gives one handshake, then IDLE.
6. Reset/parameters:
   - Assert rst for 1 cycle during MULT -> out_valid stays 0, in_ready=1 next cycle; a following 3.0 x 2.0 returns 0x40C00000.
   - Repeat tests 1-2 with BITS_PER_CYCLE=4 (latency c+9) and with EXP_W=5, MAN_W=10 (half precision): 0x4200 x 0x4000 -> 0x4600.

Source files
------------

// File: rtl/fp_mul_iterative.sv
// Sequential IEEE-754-style multiplier: radix-2^BITS_PER_CYCLE shift-add significand core,
// round-to-nearest-even, DAZ/FTZ, per-result exception flags, valid/ready on both sides.
module fp_mul_iterative #(
    parameter int EXP_W          = 8,
    parameter int MAN_W          = 23,
    parameter int BITS_PER_CYCLE = 1   // must divide MAN_W+1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_underflow,
    output logic                   flag_inexact
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int ACC_W  = 2 * SIG_W;
    localparam int N      = SIG_W / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int BIAS_I = 2 ** (EXP_W - 1) - 1;
    localparam int MAXE_I = 2 ** EXP_W - 1;

    localparam logic signed [EXP_W+1:0] BIAS     = BIAS_I[EXP_W+1:0];
    localparam logic signed [EXP_W+1:0] MAX_EXP  = MAXE_I[EXP_W+1:0];
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N - 1);
    localparam logic [W-1:0]            QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLASSIFY, MULT, ROUND, DONE} state_t;

    state_t                   state, state_next;
    logic [W-1:0]             a_q, b_q;
    logic [ACC_W-1:0]         mcand, acc;
    logic [SIG_W-1:0]         mplier;
    logic [CNT_W-1:0]         cnt;
    logic signed [EXP_W+1:0]  exp_q;

    // Operand decode (valid from CLASSIFY onward, operands held in a_q/b_q)
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;

    assign ea     = a_q[W-2 -: EXP_W];
    assign eb     = b_q[W-2 -: EXP_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign sign   = a_q[W-1] ^ b_q[W-1];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    logic signed [EXP_W+1:0] exp_sum;
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    logic [W-1:0] spec_result;
    logic         spec_invalid;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        spec_result  = {sign, {(W-1){1'b0}}};
        spec_invalid = 1'b0;
        if (a_nan || b_nan) begin
            spec_result = QNAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_result  = QNAN;
            spec_invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Normalise so the hidden bit sits just above bit ACC_W-2; norm drops that always-one bit.
    logic [ACC_W-2:0]        norm;
    logic [MAN_W-1:0]        kept_frac, frac_rnd;
    logic                    guard, sticky, round_up, carry;
    logic signed [EXP_W+1:0] exp_final;
    logic                    ovf, unf;

    assign norm      = acc[ACC_W-1] ? acc[ACC_W-2:0] : {acc[ACC_W-3:0], 1'b0};
    assign kept_frac = norm[ACC_W-2 -: MAN_W];
    assign guard     = norm[SIG_W-1];
    assign sticky    = |norm[SIG_W-2:0];
    assign round_up  = guard & (sticky | kept_frac[0]);
    assign carry     = round_up & (&kept_frac);
    assign frac_rnd  = kept_frac + MAN_W'(round_up);
    assign exp_final = exp_q + $signed({{(EXP_W+1){1'b0}}, acc[ACC_W-1]})
                             + $signed({{(EXP_W+1){1'b0}}, carry});
    assign ovf       = (exp_final >= MAX_EXP);
    assign unf       = exp_final[EXP_W+1] || (exp_final == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CLASSIFY;
            end
            CLASSIFY: state_next = special ? DONE : MULT;
            MULT:     if (cnt == LAST_CNT) state_next = ROUND;
            ROUND:    state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q            <= '0;
            b_q            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
            exp_q          <= '0;
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                end
                CLASSIFY: begin
                    if (special) begin
                        result         <= spec_result;
                        flag_invalid   <= spec_invalid;
                        flag_overflow  <= 1'b0;
                        flag_underflow <= 1'b0;
                        flag_inexact   <= 1'b0;
                    end else begin
                        mcand  <= ACC_W'({1'b1, fa});
                        mplier <= {1'b1, fb};
                        acc    <= '0;
                        cnt    <= '0;
                        exp_q  <= exp_sum;
                    end
                end
                MULT: begin
                    acc    <= acc + mcand * ACC_W'(mplier[BITS_PER_CYCLE-1:0]);
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + CNT_W'(1);
                end
                ROUND: begin
                    flag_invalid   <= 1'b0;
                    flag_overflow  <= ovf;
                    flag_underflow <= unf && !ovf;
                    if (ovf) begin
                        result       <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flag_inexact <= 1'b1;
                    end else if (unf) begin
                        result       <= {sign, {(W-1){1'b0}}};
                        flag_inexact <= 1'b1;
                    end else begin
                        result       <= {sign, exp_final[EXP_W-1:0], frac_rnd};
                        flag_inexact <= guard | sticky;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_iterative.sv
// Directed bench for fp_mul_iterative: single precision at 1 and 4 bits/cycle, plus half precision.
module tb_fp_mul_iterative;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       in_valid_v, out_ready_v;
    logic [2:0][31:0] a_v, b_v;
    wire  [2:0]       in_ready_v, out_valid_v;
    wire  [2:0][31:0] res_v;
    wire  [2:0][3:0]  flags_v;   // {invalid, overflow, underflow, inexact}

    int checks   = 0;
    int failures = 0;

    fp_mul_iterative dut_sp (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .result(res_v[0]),
        .flag_invalid(flags_v[0][3]), .flag_overflow(flags_v[0][2]),
        .flag_underflow(flags_v[0][1]), .flag_inexact(flags_v[0][0])
    );

    fp_mul_iterative #(.BITS_PER_CYCLE(4)) dut_r16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .result(res_v[1]),
        .flag_invalid(flags_v[1][3]), .flag_overflow(flags_v[1][2]),
        .flag_underflow(flags_v[1][1]), .flag_inexact(flags_v[1][0])
    );

    fp_mul_iterative #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2][15:0]), .b(b_v[2][15:0]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .result(res_v[2][15:0]),
        .flag_invalid(flags_v[2][3]), .flag_overflow(flags_v[2][2]),
        .flag_underflow(flags_v[2][1]), .flag_inexact(flags_v[2][0])
    );
    assign res_v[2][31:16] = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on DUT d; hold>0 keeps out_ready low for that many cycles after out_valid
    // while offering junk operands that must be ignored.
    task automatic op(input int d, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [31:0] er, input logic [3:0] ef, input int el, input int hold);
        int lat;
        @(negedge clk);
        check($sformatf("d%0d %h*%h in_ready idle", d, xa, xb), 32'(in_ready_v[d]), 32'd1);
        a_v[d] = xa;
        b_v[d] = xb;
        in_valid_v[d]  = 1'b1;
        out_ready_v[d] = (hold == 0);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        lat = 1;
        while (out_valid_v[d] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("d%0d %h*%h latency", d, xa, xb), 32'(lat), 32'(el));
        check($sformatf("d%0d %h*%h result", d, xa, xb), res_v[d], er);
        check($sformatf("d%0d %h*%h flags", d, xa, xb), 32'(flags_v[d]), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            a_v[d] = 32'h4F00_0000 + 32'(i);
            b_v[d] = 32'h3F80_0000;
            in_valid_v[d] = 1'b1;
            @(negedge clk);
            check($sformatf("d%0d hold%0d result", d, i), res_v[d], er);
            check($sformatf("d%0d hold%0d flags", d, i), 32'(flags_v[d]), 32'(ef));
            check($sformatf("d%0d hold%0d out_valid", d, i), 32'(out_valid_v[d]), 32'd1);
            check($sformatf("d%0d hold%0d in_ready", d, i), 32'(in_ready_v[d]), 32'd0);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        check($sformatf("d%0d %h*%h out_valid after hs", d, xa, xb), 32'(out_valid_v[d]), 32'd0);
        check($sformatf("d%0d %h*%h in_ready after hs", d, xa, xb), 32'(in_ready_v[d]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst         = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        a_v         = '0;
        b_v         = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d reset out_valid", d), 32'(out_valid_v[d]), 32'd0);
            check($sformatf("d%0d reset in_ready", d), 32'(in_ready_v[d]), 32'd1);
            check($sformatf("d%0d reset result", d), res_v[d], 32'd0);
            check($sformatf("d%0d reset flags", d), 32'(flags_v[d]), 32'd0);
        end

        // Single precision, 1 bit per cycle: normal path latency 27, specials latency 2
        op(0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 27, 0);
        op(0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, 27, 0);
        op(0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 27, 0);
        op(0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0001, 27, 0);
        op(0, 32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, 4'b0001, 27, 0);
        op(0, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101, 27, 0);
        op(0, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011, 27, 0);
        op(0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 2, 0);
        op(0, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 2, 0);
        op(0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 2, 0);
        op(0, 32'h0000_0001, 32'hC000_0000, 32'h8000_0000, 4'b0000, 2, 0);
        op(0, 32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 4'b0000, 27, 0);

        // Backpressure: result and flags held for 5 cycles, junk operands ignored
        op(0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, 27, 5);
        op(0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 27, 0);

        // Reset during MULT discards the operation
        @(negedge clk);
        a_v[0] = 32'h4040_0000;
        b_v[0] = 32'h4000_0000;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-op reset in_ready", 32'(in_ready_v[0]), 32'd1);
        check("mid-op reset out_valid", 32'(out_valid_v[0]), 32'd0);
        seen = 0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid_v[0] === 1'b1) seen = 1;
        end
        check("no output after mid-op reset", 32'(seen), 32'd0);
        op(0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 27, 0);

        // 4 bits per cycle: normal path latency 9
        op(1, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 9, 0);
        op(1, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, 9, 0);
        op(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 9, 0);
        op(1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0001, 9, 0);

        // Half precision, 1 bit per cycle: 11 MULT cycles, latency 14
        op(2, 32'h0000_4200, 32'h0000_4000, 32'h0000_4600, 4'b0000, 14, 0);
        op(2, 32'h0000_3C01, 32'h0000_3E00, 32'h0000_3E02, 4'b0001, 14, 0);
        op(2, 32'h0000_3E00, 32'h0000_3E00, 32'h0000_4080, 4'b0000, 14, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
